// File: rtl/branch_predictor_param.sv
// Tagged BTB with per-entry saturating direction counters and saturating statistics.
// Optional gshare counter indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor_param #(
  parameter int WORD_W   = 16,
  parameter int INDEX_W  = 8,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 1,
  parameter int STAT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pred_valid,
  input  logic [WORD_W-1:0]  pred_pc,
  output logic [WORD_W-1:0]  pred_next_pc,
  output logic               pred_taken,
  output logic               pred_hit,
  output logic [INDEX_W-1:0] pred_ghr,
  input  logic               upd_valid,
  input  logic [WORD_W-1:0]  upd_pc,
  input  logic [WORD_W-1:0]  upd_target,
  input  logic               upd_taken,
  input  logic               upd_cond,
  input  logic               upd_mispredict,
  input  logic [INDEX_W-1:0] upd_ghr,
  input  logic               stat_clr,
  output logic [STAT_W-1:0]  stat_lookups,
  output logic [STAT_W-1:0]  stat_mispred
);
  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = WORD_W - INDEX_W;
  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]  CTR_HALF = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0]  CTR_RST  = CTR_W'(CTR_INIT);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic              valid_q  [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [WORD_W-1:0] target_q [ENTRIES];

  logic [STAT_W-1:0] lookups_q, lookups_d;
  logic [STAT_W-1:0] mispred_q, mispred_d;

  logic [INDEX_W-1:0] idx, cidx, uidx, ucidx;
  logic [TAG_W-1:0]   tag, utag;

  assign idx  = pred_pc[INDEX_W-1:0];
  assign tag  = pred_pc[WORD_W-1:INDEX_W];
  assign uidx = upd_pc[INDEX_W-1:0];
  assign utag = upd_pc[WORD_W-1:INDEX_W];

`ifdef BP_GSHARE_EN
  logic [INDEX_W-1:0] ghr_q, ghr_d;

  assign cidx     = idx ^ ghr_q;
  assign ucidx    = uidx ^ upd_ghr;
  assign pred_ghr = ghr_q;

  // History only advances on resolved conditional branches (non-speculative).
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && upd_cond)
      ghr_d = {ghr_q[INDEX_W-2:0], upd_taken};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ghr_q <= '0;
    else          ghr_q <= ghr_d;
  end
`else
  logic unused_upd_ghr;

  assign cidx           = idx;
  assign ucidx          = uidx;
  assign pred_ghr       = '0;
  assign unused_upd_ghr = ^upd_ghr;
`endif

  always_comb begin
    pred_hit     = valid_q[idx] && (tag_q[idx] == tag);
    pred_taken   = pred_hit && ctr_q[cidx][CTR_W-1];
    pred_next_pc = pred_taken ? target_q[idx] : pred_pc + WORD_W'(1);
  end

  logic             u_hit;
  logic [CTR_W-1:0] u_ctr;
  logic             tab_we, ctr_we;
  logic [CTR_W-1:0] ctr_wdata;

  always_comb begin
    u_hit     = valid_q[uidx] && (tag_q[uidx] == utag);
    u_ctr     = ctr_q[ucidx];
    tab_we    = 1'b0;
    ctr_we    = 1'b0;
    ctr_wdata = u_ctr;
    if (upd_valid) begin
      if (!upd_cond) begin
        tab_we    = 1'b1;
        ctr_we    = 1'b1;
        ctr_wdata = CTR_MAX;
      end else if (upd_taken) begin
        tab_we    = 1'b1;
        ctr_we    = 1'b1;
        if (!u_hit)               ctr_wdata = CTR_HALF;
        else if (u_ctr != CTR_MAX) ctr_wdata = u_ctr + CTR_W'(1);
      end else if (u_hit) begin
        ctr_we = 1'b1;
        if (u_ctr != '0) ctr_wdata = u_ctr - CTR_W'(1);
      end
    end
  end

  always_comb begin
    lookups_d = lookups_q;
    mispred_d = mispred_q;
    if (stat_clr) begin
      lookups_d = '0;
      mispred_d = '0;
    end else begin
      if (pred_valid && lookups_q != STAT_MAX)
        lookups_d = lookups_q + STAT_W'(1);
      if (upd_valid && upd_mispredict && mispred_q != STAT_MAX)
        mispred_d = mispred_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RST;
      end
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      if (tab_we) valid_q[uidx] <= 1'b1;
      if (ctr_we) ctr_q[ucidx]  <= ctr_wdata;
      lookups_q <= lookups_d;
      mispred_q <= mispred_d;
    end
  end

  // Tag/target need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge clk) begin
    if (tab_we) begin
      tag_q[uidx]    <= utag;
      target_q[uidx] <= upd_target;
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_mispred = mispred_q;
endmodule

// File: tb/tb_branch_predictor_param.sv
// Directed test of branch_predictor_param (default parameters; gshare scenario when BP_GSHARE_EN is defined).
module tb_branch_predictor_param;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        pred_valid;
  logic [15:0] pred_pc;
  logic [15:0] pred_next_pc;
  logic        pred_taken;
  logic        pred_hit;
  logic [7:0]  pred_ghr;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic        upd_cond;
  logic        upd_mispredict;
  logic [7:0]  upd_ghr;
  logic        stat_clr;
  logic [15:0] stat_lookups;
  logic [15:0] stat_mispred;

  int total = 0;
  int bad   = 0;

  branch_predictor_param dut (
    .clk(clk), .reset_n(reset_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_next_pc(pred_next_pc),
    .pred_taken(pred_taken), .pred_hit(pred_hit), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_cond(upd_cond), .upd_mispredict(upd_mispredict),
    .upd_ghr(upd_ghr), .stat_clr(stat_clr),
    .stat_lookups(stat_lookups), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [15:0] pc);
    pred_pc = pc;
    #1;
  endtask

  task automatic upd(input logic [15:0] pc, input logic [15:0] tgt,
                     input logic taken, input logic cond);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_target = tgt;
    upd_taken  = taken;
    upd_cond   = cond;
    tick();
    upd_valid  = 1'b0;
    $display("upd pc=%h tgt=%h taken=%0d cond=%0d", pc, tgt, taken, cond);
  endtask

  task automatic chk_pred(input string name, input logic [15:0] pc,
                          input logic hit, input logic tk, input logic [15:0] nxt);
    look(pc);
    total++;
    if (pred_hit !== hit || pred_taken !== tk || pred_next_pc !== nxt) begin
      bad++;
      $display("FAIL %s: pc=%h got hit=%0d taken=%0d next=%h want hit=%0d taken=%0d next=%h",
               name, pc, pred_hit, pred_taken, pred_next_pc, hit, tk, nxt);
    end else
      $display("ok   %s: pc=%h hit=%0d taken=%0d next=%h", name, pc, hit, tk, nxt);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pred_valid = 1'b0; pred_pc = '0; upd_valid = 1'b0;
    upd_pc = '0; upd_target = '0; upd_taken = 1'b0; upd_cond = 1'b0;
    upd_mispredict = 1'b0; upd_ghr = '0; stat_clr = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk_pred("reset_lookup", 16'h0010, 1'b0, 1'b0, 16'h0011);
    total++;
    if (stat_lookups !== 16'h0 || stat_mispred !== 16'h0 || pred_ghr !== 8'h0) begin
      bad++;
      $display("FAIL reset_state: got lookups=%h mispred=%h ghr=%h want 0/0/0",
               stat_lookups, stat_mispred, pred_ghr);
    end else $display("ok   reset_state");
  endtask

  task automatic test_counter();
    upd(16'h0010, 16'h0020, 1'b1, 1'b1);
    chk_pred("alloc", 16'h0010, 1'b1, 1'b1, 16'h0020);
    upd(16'h0010, 16'h0020, 1'b0, 1'b1);
    chk_pred("ctr_1", 16'h0010, 1'b1, 1'b0, 16'h0011);
    upd(16'h0010, 16'h0020, 1'b0, 1'b1);
    upd(16'h0010, 16'h0020, 1'b0, 1'b1);
    upd(16'h0010, 16'h0020, 1'b1, 1'b1);
    chk_pred("ctr_floor_then_1", 16'h0010, 1'b1, 1'b0, 16'h0011);
    upd(16'h0010, 16'h0020, 1'b1, 1'b1);
    chk_pred("ctr_2", 16'h0010, 1'b1, 1'b1, 16'h0020);
    repeat (3) upd(16'h0010, 16'h0020, 1'b1, 1'b1);
    upd(16'h0010, 16'h0020, 1'b0, 1'b1);
    chk_pred("ctr_sat_minus1", 16'h0010, 1'b1, 1'b1, 16'h0020);
    upd(16'h0010, 16'h0020, 1'b0, 1'b1);
    chk_pred("ctr_sat_minus2", 16'h0010, 1'b1, 1'b0, 16'h0011);
    upd(16'h0050, 16'h0099, 1'b0, 1'b1);
    chk_pred("nt_miss_no_alloc", 16'h0050, 1'b0, 1'b0, 16'h0051);
  endtask

  task automatic test_alias();
    chk_pred("alias_miss", 16'h0110, 1'b0, 1'b0, 16'h0111);
    upd(16'h0110, 16'h0200, 1'b0, 1'b0);
    chk_pred("jump_replace", 16'h0110, 1'b1, 1'b1, 16'h0200);
    chk_pred("old_evicted", 16'h0010, 1'b0, 1'b0, 16'h0011);
    chk_pred("wrap", 16'hFFFF, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_same_cycle();
    look(16'h0110);
    upd_valid = 1'b1; upd_pc = 16'h0110; upd_target = 16'h0300;
    upd_taken = 1'b1; upd_cond = 1'b1;
    chk_pred("same_cycle_old", 16'h0110, 1'b1, 1'b1, 16'h0200);
    tick();
    upd_valid = 1'b0;
    chk_pred("same_cycle_new", 16'h0110, 1'b1, 1'b1, 16'h0300);
    upd_valid = 1'b1; upd_pc = 16'h0040; upd_target = 16'h0123;
    chk_pred("same_cycle_alloc_old", 16'h0040, 1'b0, 1'b0, 16'h0041);
    tick();
    upd_valid = 1'b0;
    chk_pred("same_cycle_alloc_new", 16'h0040, 1'b1, 1'b1, 16'h0123);
  endtask

  task automatic test_async_reset();
    look(16'h0040);
    @(posedge clk);
    #3 reset_n = 1'b0;
    chk_pred("async_reset", 16'h0040, 1'b0, 1'b0, 16'h0041);
    upd_valid = 1'b1; upd_pc = 16'h0060; upd_target = 16'h0777;
    upd_taken = 1'b1; upd_cond = 1'b0;
    tick();
    upd_valid = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    chk_pred("reset_drops_write", 16'h0060, 1'b0, 1'b0, 16'h0061);
  endtask

  task automatic test_stats();
    upd_mispredict = 1'b1;
    repeat (3) upd(16'h0070, 16'h0000, 1'b0, 1'b1);
    total++;
    if (stat_mispred !== 16'd3) begin
      bad++; $display("FAIL mispred_count: got %0d want 3", stat_mispred);
    end else $display("ok   mispred_count=3");
    stat_clr = 1'b1;
    upd(16'h0070, 16'h0000, 1'b0, 1'b1);
    stat_clr = 1'b0; upd_mispredict = 1'b0;
    total++;
    if (stat_mispred !== 16'd0) begin
      bad++; $display("FAIL clr_priority_mispred: got %0d want 0", stat_mispred);
    end else $display("ok   clr_priority_mispred");
    pred_valid = 1'b1;
    repeat (5) tick();
    total++;
    if (stat_lookups !== 16'd5 || stat_mispred !== 16'd0) begin
      bad++; $display("FAIL lookup_count: got %0d/%0d want 5/0", stat_lookups, stat_mispred);
    end else $display("ok   lookup_count=5");
    repeat (65539) @(posedge clk);
    #1;
    pred_valid = 1'b0;
    tick();
    total++;
    if (stat_lookups !== 16'hFFFF) begin
      bad++; $display("FAIL lookup_saturate: got %h want ffff", stat_lookups);
    end else $display("ok   lookup_saturate");
    pred_valid = 1'b1; stat_clr = 1'b1;
    tick();
    pred_valid = 1'b0; stat_clr = 1'b0;
    total++;
    if (stat_lookups !== 16'h0) begin
      bad++; $display("FAIL clr_priority_lookups: got %h want 0", stat_lookups);
    end else $display("ok   clr_priority_lookups");
  endtask

`ifdef BP_GSHARE_EN
  task automatic test_gshare();
    upd(16'h0A01, 16'h0000, 1'b1, 1'b1);
    upd(16'h0A02, 16'h0000, 1'b1, 1'b1);
    look(16'h0010);
    total++;
    if (pred_ghr !== 8'h03) begin
      bad++; $display("FAIL ghr_11: got %h want 03", pred_ghr);
    end else $display("ok   ghr=03");
    upd_ghr = 8'h03;
    upd(16'h0010, 16'h0020, 1'b1, 1'b0);
    upd_ghr = 8'h00;
    chk_pred("gshare_cidx_13", 16'h0010, 1'b1, 1'b1, 16'h0020);
    upd(16'h0A03, 16'h0000, 1'b0, 1'b1);
    total++;
    if (pred_ghr !== 8'h06) begin
      bad++; $display("FAIL ghr_110: got %h want 06", pred_ghr);
    end else $display("ok   ghr=06");
    chk_pred("gshare_cidx_16", 16'h0010, 1'b1, 1'b0, 16'h0011);
  endtask
`endif

  initial begin
    test_reset();
`ifdef BP_GSHARE_EN
    test_gshare();
`else
    test_counter();
    test_alias();
    test_same_cycle();
    test_async_reset();
`endif
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
